// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and error-flag bit positions for the passive bus monitor.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_e;

    localparam int ERR_SEQ_OUTSIDE = 0;
    localparam int ERR_UNSTABLE    = 1;
    localparam int ERR_BAD_SEQ     = 2;
    localparam int ERR_ILLEGAL     = 3;

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks whether a burst is in progress and the address the next SEQ beat must carry.
module ahb_burst_tracker
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  htrans_e           trans,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic              ready,
    input  logic              resp,
    output logic              seq_outside,
    output logic              bad_seq
);

    logic              active;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;

    always_comb begin
        accept      = ready && (trans == NONSEQ || trans == SEQ);
        seq_outside = ready && (trans == SEQ || trans == BUSY) && !active;
        bad_seq     = accept && (trans == SEQ) && active && (addr != next_addr);
    end

    // BUSY leaves the burst untouched; a completed ERROR or an IDLE slot ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            next_addr <= '0;
        end else begin
            if (ready && (resp || trans == IDLE))
                active <= 1'b0;
            else if (accept)
                active <= 1'b1;
            if (accept)
                next_addr <= addr + (ADDR_W'(1) << size);
        end
    end

endmodule

// File: rtl/ahb_lite_monitor.sv
// Passive AHB-Lite monitor: one record per completed data phase, sticky protocol
// error flags and saturating OKAY transfer counters.
module ahb_lite_monitor
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic              clr,
    output logic              mon_valid,
    output logic              mon_write,
    output logic [ADDR_W-1:0] mon_addr,
    output logic [DATA_W-1:0] mon_data,
    output logic              mon_resp,
    output logic [3:0]        err_flags,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam logic [0:0] NO_DATA   = 1'b0;
    localparam logic [0:0] DATA_PEND = 1'b1;
    localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_W / 8));

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              resp;
    } mon_rec_t;

    htrans_e           trans;
    logic              accept;
    logic              complete;
    logic [0:0]        state;
    logic              pend_write;
    logic [ADDR_W-1:0] pend_addr;
    mon_rec_t          rec;

    logic              hold_chk;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_write;
    logic [2:0]        hold_size;
    htrans_e           hold_trans;
    logic              resp_wait;

    logic              seq_outside;
    logic              bad_seq;
    logic              unstable;
    logic              illegal;
    logic [3:0]        viol;

    ahb_burst_tracker #(.ADDR_W(ADDR_W)) u_burst (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .trans       (trans),
        .addr        (HADDR),
        .size        (HSIZE),
        .ready       (HREADY),
        .resp        (HRESP),
        .seq_outside (seq_outside),
        .bad_seq     (bad_seq)
    );

    // NOTE: every always_comb output gets a value on every path (viol defaults first), so no latch is inferred.
    always_comb begin
        trans    = htrans_e'(HTRANS);
        accept   = HREADY && (trans == NONSEQ || trans == SEQ);
        complete = (state == DATA_PEND) && HREADY;
        unstable = hold_chk && ((HADDR != hold_addr) || (HWRITE != hold_write) ||
                   (HSIZE != hold_size) ||
                   ((trans != hold_trans) && !(hold_trans == BUSY && trans == SEQ)));
        illegal  = (accept && (HSIZE > MAX_SIZE)) || (HREADY && HRESP && !resp_wait);
        viol                  = '0;
        viol[ERR_SEQ_OUTSIDE] = seq_outside;
        viol[ERR_UNSTABLE]    = unstable;
        viol[ERR_BAD_SEQ]     = bad_seq;
        viol[ERR_ILLEGAL]     = illegal;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= NO_DATA;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            mon_valid  <= 1'b0;
            rec        <= '0;
        end else begin
            if (HREADY)
                state <= accept ? DATA_PEND : NO_DATA;
            if (accept) begin
                pend_write <= HWRITE;
                pend_addr  <= HADDR;
            end
            mon_valid <= complete;
            if (complete)
                rec <= '{write: pend_write, addr: pend_addr,
                         data: pend_write ? HWDATA : HRDATA, resp: HRESP};
        end
    end

    // Snapshot of an address phase stalled while no data phase owns the wait state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_chk   <= 1'b0;
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_trans <= IDLE;
            resp_wait  <= 1'b0;
        end else begin
            hold_chk   <= (state == NO_DATA) && !HREADY && (trans != IDLE);
            hold_addr  <= HADDR;
            hold_write <= HWRITE;
            hold_size  <= HSIZE;
            hold_trans <= trans;
            resp_wait  <= HRESP && !HREADY;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            err_pulse <= |viol;
            if (clr) begin
                err_flags <= '0;
                wr_count  <= '0;
                rd_count  <= '0;
            end else begin
                err_flags <= err_flags | viol;
                if (complete && !HRESP) begin
                    if (pend_write) begin
                        if (wr_count != '1)
                            wr_count <= wr_count + CNT_W'(1);
                    end else begin
                        if (rd_count != '1)
                            rd_count <= rd_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign mon_write = rec.write;
    assign mon_addr  = rec.addr;
    assign mon_data  = rec.data;
    assign mon_resp  = rec.resp;

endmodule

// File: tb/tb_ahb_lite_monitor.sv
// Self-checking bench for ahb_lite_monitor: table-driven single transfers plus
// hand-written burst, error, wrap, saturation and reset sequences, with a record scoreboard.
module tb_ahb_lite_monitor;
    import ahb_pkg::*;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          HCLK;
    logic          HRESETn;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic          clr;
    logic          mon_valid;
    logic          mon_write;
    logic [AW-1:0] mon_addr;
    logic [DW-1:0] mon_data;
    logic          mon_resp;
    logic [3:0]    err_flags;
    logic          err_pulse;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;

    ahb_lite_monitor #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .clr       (clr),
        .mon_valid (mon_valid),
        .mon_write (mon_write),
        .mon_addr  (mon_addr),
        .mon_data  (mon_data),
        .mon_resp  (mon_resp),
        .err_flags (err_flags),
        .err_pulse (err_pulse),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          r;
        int            cyc;
    } rec_t;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            waits;
        logic          resp;
    } vec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle_no = 0;
    int   pulse_cnt = 0;
    int   wr_exp = 0;
    int   rd_exp = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cycle_no <= cycle_no + 1;

    always @(negedge HCLK) begin
        rec_t o;
        if (mon_valid) begin
            o.w = mon_write; o.a = mon_addr; o.d = mon_data; o.r = mon_resp; o.cyc = cycle_no;
            obs_q.push_back(o);
        end
        if (err_pulse) pulse_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic drain();
        rec_t o, e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got addr 0x%0h at cycle %0d, want none", o.a, o.cyc);
            end else begin
                e = exp_q.pop_front();
                check("rec_write", o.w, e.w);
                check("rec_addr", o.a, e.a);
                check("rec_data", o.d, e.d);
                check("rec_resp", o.r, e.r);
                check("rec_cycle", o.cyc, e.cyc);
            end
        end
    endtask

    // Called just before driving the cycle whose rising edge completes the data phase.
    task automatic expect_rec(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
        rec_t e;
        e.w = w; e.a = a; e.d = d; e.r = r; e.cyc = cycle_no + 1;
        exp_q.push_back(e);
        if (!r) begin
            if (w) wr_exp = sat_inc(wr_exp);
            else   rd_exp = sat_inc(rd_exp);
        end
    endtask

    task automatic bus_cycle(input logic [1:0] t, input logic [AW-1:0] a, input logic w,
                             input logic [2:0] s, input logic rdy, input logic rsp,
                             input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        HTRANS = t; HADDR = a; HWRITE = w; HSIZE = s;
        HREADY = rdy; HRESP = rsp; HWDATA = wd; HRDATA = rd;
        @(posedge HCLK);
        #1;
        drain();
    endtask

    task automatic idle();
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle();
        clr = 1'b0;
        wr_exp = 0;
        rd_exp = 0;
    endtask

    task automatic do_xfer(input vec_t v);
        bus_cycle(NONSEQ, v.addr, v.write, 3'd0, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
        for (int i = 0; i < v.waits; i++)
            bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b0, v.resp && (i == v.waits - 1),
                      DW'($urandom), DW'($urandom));
        expect_rec(v.write, v.addr, v.data, v.resp);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, v.resp,
                  v.write ? v.data : ~v.data, v.write ? ~v.data : v.data);
    endtask

    task automatic burst(input logic [AW-1:0] third);
        bus_cycle(NONSEQ, 21'h100, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        expect_rec(1'b1, 21'h100, 8'h11, 1'b0);
        bus_cycle(SEQ, 21'h101, 1'b1, 3'd0, 1'b1, 1'b0, 8'h11, 8'h00);
        expect_rec(1'b1, 21'h101, 8'h22, 1'b0);
        bus_cycle(BUSY, 21'h102, 1'b1, 3'd0, 1'b1, 1'b0, 8'h22, 8'h00);
        bus_cycle(SEQ, third, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        expect_rec(1'b1, third, 8'h33, 1'b0);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h33, 8'h00);
        idle();
    endtask

    initial begin
        vec_t vecs[6];
        int   p0;
        vecs[0] = '{write: 1'b1, addr: 21'h00010, data: 8'hA5, waits: 0, resp: 1'b0};
        vecs[1] = '{write: 1'b0, addr: 21'h00020, data: 8'h3C, waits: 2, resp: 1'b0};
        vecs[2] = '{write: 1'b1, addr: 21'h1ABCD, data: 8'h5A, waits: 1, resp: 1'b0};
        vecs[3] = '{write: 1'b0, addr: 21'h00FFF, data: 8'hC3, waits: 0, resp: 1'b0};
        vecs[4] = '{write: 1'b1, addr: 21'h00030, data: 8'h11, waits: 3, resp: 1'b0};
        vecs[5] = '{write: 1'b0, addr: 21'h00040, data: 8'h77, waits: 1, resp: 1'b1};

        HRESETn = 1'b0; clr = 1'b0;
        HTRANS = IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
        HWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_mon_valid", mon_valid, 1'b0);
        check("rst_mon_addr", mon_addr, '0);
        check("rst_err_flags", err_flags, 4'h0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_wr_count", wr_count, '0);
        check("rst_rd_count", rd_count, '0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i]);
            idle();
            check("vec_wr_count", wr_count, wr_exp);
            check("vec_rd_count", rd_count, rd_exp);
            check("vec_err_flags", err_flags, 4'h0);
        end

        p0 = pulse_cnt;
        burst(21'h102);
        check("burst_ok_flags", err_flags, 4'h0);
        check("burst_ok_pulses", pulse_cnt - p0, 0);

        p0 = pulse_cnt;
        burst(21'h104);
        check("burst_bad_flags", err_flags, 4'b0100);
        check("burst_bad_pulses", pulse_cnt - p0, 1);

        do_clr();
        idle();
        bus_cycle(SEQ, 21'h200, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("seq_outside_flag", err_flags, 4'b0001);
        clr = 1'b1;
        expect_rec(1'b0, 21'h200, 8'h99, 1'b0);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h99);
        clr = 1'b0;
        wr_exp = 0;
        rd_exp = 0;
        check("clr_err_flags", err_flags, 4'h0);
        check("clr_beats_incr", rd_count, rd_exp);
        idle();

        bus_cycle(NONSEQ, 21'h1FFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        expect_rec(1'b0, 21'h1FFFFF, 8'h44, 1'b0);
        bus_cycle(SEQ, 21'h000000, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h44);
        expect_rec(1'b0, 21'h000000, 8'h55, 1'b0);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h55);
        idle();
        check("wrap_err_flags", err_flags, 4'h0);
        check("wrap_rd_count", rd_count, rd_exp);

        bus_cycle(NONSEQ, 21'h400, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        bus_cycle(NONSEQ, 21'h404, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("unstable_flag", err_flags, 4'b0010);
        expect_rec(1'b1, 21'h404, 8'h66, 1'b0);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h66, 8'h00);
        idle();

        do_clr();
        bus_cycle(NONSEQ, 21'h600, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h00);
        check("hsize_flag", err_flags, 4'b1000);
        expect_rec(1'b1, 21'h600, 8'h77, 1'b0);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h77, 8'h00);
        idle();

        do_clr();
        bus_cycle(NONSEQ, 21'h300, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        p0 = pulse_cnt;
        expect_rec(1'b1, 21'h300, 8'h88, 1'b1);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h88, 8'h00);
        idle();
        check("one_cycle_error_flag", err_flags, 4'b1000);
        check("one_cycle_error_pulses", pulse_cnt - p0, 1);
        check("error_not_counted", wr_count, wr_exp);

        do_clr();
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            v = '{write: 1'b1, addr: AW'(32'h700 + i), data: DW'(i + 1), waits: 0, resp: 1'b0};
            do_xfer(v);
        end
        idle();
        check("sat_wr_count", wr_count, wr_exp);
        check("sat_wr_count_max", wr_count, CNT_MAX);

        bus_cycle(NONSEQ, 21'h500, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00);
        bus_cycle(IDLE, '0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'hEE);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_mon_addr", mon_addr, '0);
        check("midrst_mon_data", mon_data, '0);
        check("midrst_mon_write", mon_write, 1'b0);
        check("midrst_wr_count", wr_count, '0);
        check("midrst_err_flags", err_flags, 4'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        wr_exp = 0;
        rd_exp = 0;
        repeat (3) idle();
        check("postrst_mon_valid", mon_valid, 1'b0);
        check("postrst_rd_count", rd_count, rd_exp);

        repeat (2) idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
